// File: rtl/shiftreg_pkg.sv
// rtl/shiftreg_pkg.sv - shared types and helpers for the universal shift register
package shiftreg_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'b00,
    MODE_SIPO   = 2'b01,
    MODE_PISO   = 2'b10,
    MODE_ROTATE = 2'b11
  } shift_mode_t;

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shiftreg_bitcnt.sv
// rtl/shiftreg_bitcnt.sv - bit counter wrapping at WIDTH-1 with clear and increment
module shiftreg_bitcnt
  import shiftreg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic last
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST_VAL = CW'(WIDTH - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] base;

  // clr acts before inc, so a cleared count can still take this cycle's bit
  always_comb base = clr ? '0 : cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= (base == LAST_VAL) ? '0 : base + CW'(1);
    end else begin
      cnt <= base;
    end
  end

  assign last = (cnt == LAST_VAL);

endmodule

// File: rtl/shiftreg_serdes.sv
// rtl/shiftreg_serdes.sv - run-time selectable SIPO / PISO / rotate shift register
module shiftreg_serdes
  import shiftreg_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic             in_serial,
  input  logic             in_serial_valid,
  input  logic [WIDTH-1:0] in_parallel,
  input  logic             in_load,
  output logic             out_serial,
  output logic             out_serial_valid,
  output logic [WIDTH-1:0] out_parallel,
  output logic             out_parallel_valid,
  output logic             out_busy
);

  shift_mode_t      mode_cur, mode_q;
  logic [WIDTH-1:0] shreg, shreg_d, par_d;
  logic [WIDTH-1:0] sipo_next, piso_next, rot_next;
  logic             chg, busy_eff, last_eff, cnt_last;
  logic             cnt_clr, cnt_inc, load_acc;
  logic             ser_d, ser_v_d, par_v_d, busy_d;

  function automatic logic out_end(input logic [WIDTH-1:0] v);
    return LSB_FIRST ? v[0] : v[WIDTH-1];
  endfunction

  assign mode_cur = shift_mode_t'(mode);
  assign chg      = (mode_cur != mode_q);
  // a mode change aborts the frame: treat count and busy as already cleared
  assign busy_eff = out_busy & ~chg;
  assign last_eff = cnt_last & ~chg;

  assign sipo_next = LSB_FIRST ? {in_serial, shreg[WIDTH-1:1]} : {shreg[WIDTH-2:0], in_serial};
  assign piso_next = LSB_FIRST ? {1'b0, shreg[WIDTH-1:1]}      : {shreg[WIDTH-2:0], 1'b0};
  assign rot_next  = LSB_FIRST ? {shreg[0], shreg[WIDTH-1:1]}  : {shreg[WIDTH-2:0], shreg[WIDTH-1]};

  shiftreg_bitcnt #(.WIDTH(WIDTH)) u_bitcnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .last (cnt_last)
  );

  always_comb begin
    shreg_d  = shreg;
    par_d    = out_parallel;
    par_v_d  = 1'b0;
    ser_d    = 1'b0;
    ser_v_d  = 1'b0;
    busy_d   = 1'b0;
    cnt_clr  = chg;
    cnt_inc  = 1'b0;
    load_acc = 1'b0;
    case (mode_cur)
      MODE_SIPO: begin
        if (in_serial_valid) begin
          shreg_d = sipo_next;
          cnt_inc = 1'b1;
          if (last_eff) begin
            par_d   = sipo_next;
            par_v_d = 1'b1;
          end
        end
      end
      MODE_PISO: begin
        // reload on the final bit keeps back-to-back words gapless
        load_acc = in_load & (~busy_eff | last_eff);
        if (load_acc) begin
          shreg_d = in_parallel;
          cnt_clr = 1'b1;
          busy_d  = 1'b1;
          ser_v_d = 1'b1;
          ser_d   = out_end(in_parallel);
        end else if (busy_eff) begin
          shreg_d = piso_next;
          cnt_inc = 1'b1;
          busy_d  = ~last_eff;
          ser_v_d = ~last_eff;
          ser_d   = ~last_eff & out_end(piso_next);
        end
      end
      MODE_ROTATE: begin
        shreg_d = rot_next;
        par_d   = rot_next;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q             <= MODE_HOLD;
      shreg              <= '0;
      out_parallel       <= '0;
      out_parallel_valid <= 1'b0;
      out_serial         <= 1'b0;
      out_serial_valid   <= 1'b0;
      out_busy           <= 1'b0;
    end else begin
      mode_q             <= mode_cur;
      shreg              <= shreg_d;
      out_parallel       <= par_d;
      out_parallel_valid <= par_v_d;
      out_serial         <= ser_d;
      out_serial_valid   <= ser_v_d;
      out_busy           <= busy_d;
    end
  end

endmodule

// File: tb/tb_shiftreg_serdes.sv
// tb/tb_shiftreg_serdes.sv - directed bench with a bit-queue reference model for both bit orders
module tb_shiftreg_serdes;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] mode;
  logic       in_serial, in_serial_valid, in_load;
  logic [7:0] in_parallel;
  logic [1:0] o_s, o_sv, o_pv, o_busy;
  logic [7:0] o_par [2];

  int n_checks = 0;
  int n_err    = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  shiftreg_serdes #(.WIDTH(8), .LSB_FIRST(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_serial(in_serial),
    .in_serial_valid(in_serial_valid), .in_parallel(in_parallel), .in_load(in_load),
    .out_serial(o_s[0]), .out_serial_valid(o_sv[0]), .out_parallel(o_par[0]),
    .out_parallel_valid(o_pv[0]), .out_busy(o_busy[0])
  );

  shiftreg_serdes #(.WIDTH(8), .LSB_FIRST(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_serial(in_serial),
    .in_serial_valid(in_serial_valid), .in_parallel(in_parallel), .in_load(in_load),
    .out_serial(o_s[1]), .out_serial_valid(o_sv[1]), .out_parallel(o_par[1]),
    .out_parallel_valid(o_pv[1]), .out_busy(o_busy[1])
  );

  // reference model: SIPO bit tally, PISO "bits still to show" counter
  typedef struct {
    logic [7:0] shreg;
    logic [7:0] word;
    logic [7:0] par;
    int         cnt;
    int         left;
    logic [1:0] modeq;
    logic       pv;
    logic       sv;
    logic       s;
    logic       busy;
  } mstate_t;

  mstate_t ms [2];

  function automatic mstate_t model_next(mstate_t c, bit lsb, logic rn, logic [1:0] md,
                                         logic si, logic siv, logic ld, logic [7:0] pin);
    mstate_t n;
    int idx;
    n = c;
    if (!rn) begin
      n = '{shreg: 8'h00, word: 8'h00, par: 8'h00, cnt: 0, left: 0, modeq: 2'd0,
            pv: 1'b0, sv: 1'b0, s: 1'b0, busy: 1'b0};
      return n;
    end
    if (md != c.modeq) begin
      n.cnt  = 0;
      n.left = 0;
    end
    n.modeq = md;
    n.pv    = 1'b0;
    case (md)
      2'd1: if (siv) begin
        n.shreg = lsb ? ((c.shreg >> 1) | (8'(si) << 7)) : ((c.shreg << 1) | 8'(si));
        n.cnt   = n.cnt + 1;
        if (n.cnt == 8) begin
          n.cnt = 0;
          n.par = n.shreg;
          n.pv  = 1'b1;
        end
      end
      2'd2: begin
        if (ld && n.left <= 1) begin
          n.word  = pin;
          n.shreg = pin;
          n.left  = 8;
        end else if (n.left > 0) begin
          n.left  = n.left - 1;
          n.shreg = lsb ? (c.shreg >> 1) : (c.shreg << 1);
        end
      end
      2'd3: begin
        n.shreg = lsb ? ((c.shreg >> 1) | (c.shreg << 7)) : ((c.shreg << 1) | (c.shreg >> 7));
        n.par   = n.shreg;
      end
      default: ;
    endcase
    n.sv   = (n.left > 0);
    n.busy = n.sv;
    n.s    = 1'b0;
    if (n.left > 0) begin
      idx = 8 - n.left;
      n.s = lsb ? n.word[idx] : n.word[7 - idx];
    end
    return n;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      ms[i] <= model_next(ms[i], i[0], rst_n, mode, in_serial, in_serial_valid, in_load, in_parallel);
  end

  task automatic check(input string name, input int inst, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s u%0d: got %h expected %h at %0t", name, inst, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      for (int i = 0; i < 2; i++) begin
        check("par",  i, o_par[i],         ms[i].par);
        check("pv",   i, 8'(o_pv[i]),      8'(ms[i].pv));
        check("ser",  i, 8'(o_s[i]),       8'(ms[i].s));
        check("sv",   i, 8'(o_sv[i]),      8'(ms[i].sv));
        check("busy", i, 8'(o_busy[i]),    8'(ms[i].busy));
      end
    end
  end

  task automatic step(input logic [1:0] md, input logic siv, input logic si,
                      input logic ld, input logic [7:0] p);
    mode            = md;
    in_serial_valid = siv;
    in_serial       = si;
    in_load         = ld;
    in_parallel     = p;
    @(posedge clk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int k = 7; k >= 0; k--) step(2'd1, 1'b1, b[k], 1'b0, 8'h00);
  endtask

  initial begin
    logic [7:0] rx, rx2;
    int         nvalid;

    rst_n = 1'b0;
    step(2'd0, 1'b0, 1'b0, 1'b0, 8'h00);
    step(2'd0, 1'b0, 1'b0, 1'b0, 8'h00);
    check_en = 1'b1;
    check("rst_par",  0, o_par[0],          8'h00);
    check("rst_busy", 0, 8'(o_busy[0]),     8'h00);
    rst_n = 1'b1;

    // bits 1,0,1,1,0,0,1,0
    step(2'd1, 1'b0, 1'b0, 1'b0, 8'h00);
    send_byte(8'hB2);
    check("t1_par",   0, o_par[0],      8'hB2);
    check("t1_pv",    0, 8'(o_pv[0]),   8'h01);
    check("t1_par",   1, o_par[1],      8'h4D);
    check("t1_model", 0, ms[0].par,     8'hB2);
    check("t1_model", 1, ms[1].par,     8'h4D);
    step(2'd1, 1'b0, 1'b0, 1'b0, 8'h00);
    check("t1_pv_end", 0, 8'(o_pv[0]),  8'h00);

    // reset mid-frame, with a load request that reset must override
    for (int k = 0; k < 5; k++) step(2'd1, 1'b1, k[0], 1'b0, 8'h00);
    rst_n = 1'b0;
    step(2'd2, 1'b0, 1'b0, 1'b1, 8'hFF);
    check("t5_rst_par", 0, o_par[0],      8'h00);
    check("t5_rst_sv",  1, 8'(o_sv[1]),   8'h00);
    step(2'd2, 1'b0, 1'b0, 1'b1, 8'hFF);
    check("t5_rst_busy", 0, 8'(o_busy[0]), 8'h00);
    rst_n = 1'b1;
    step(2'd1, 1'b0, 1'b0, 1'b0, 8'h00);
    send_byte(8'h5A);
    check("t5_par", 0, o_par[0], 8'h5A);
    check("t5_par", 1, o_par[1], 8'h5A);

    // 3-cycle valid gap between bits 4 and 5; ignored bits are 1s
    step(2'd1, 1'b1, 1'b1, 1'b0, 8'h00);
    step(2'd1, 1'b1, 1'b0, 1'b0, 8'h00);
    step(2'd1, 1'b1, 1'b1, 1'b0, 8'h00);
    step(2'd1, 1'b1, 1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 3; k++) step(2'd1, 1'b0, 1'b1, 1'b0, 8'h00);
    step(2'd1, 1'b1, 1'b0, 1'b0, 8'h00);
    step(2'd1, 1'b1, 1'b0, 1'b0, 8'h00);
    step(2'd1, 1'b1, 1'b1, 1'b0, 8'h00);
    check("t2_pv_early", 0, 8'(o_pv[0]), 8'h00);
    step(2'd1, 1'b1, 1'b0, 1'b0, 8'h00);
    check("t2_par", 0, o_par[0],    8'hB2);
    check("t2_pv",  0, 8'(o_pv[0]), 8'h01);
    check("t2_par", 1, o_par[1],    8'h4D);

    // PISO A5 with an ignored mid-word load of FF
    step(2'd2, 1'b0, 1'b0, 1'b1, 8'hA5);
    rx = 8'h00;
    for (int i = 0; i < 8; i++) begin
      check("t3_sv", 0, 8'(o_sv[0]), 8'h01);
      rx = {rx[6:0], o_s[0]};
      step(2'd2, 1'b0, 1'b0, (i == 3), 8'hFF);
    end
    check("t3_word", 0, rx,             8'hA5);
    check("t3_busy", 0, 8'(o_busy[0]),  8'h00);

    // back-to-back A5 then 3C loaded on the final bit
    step(2'd2, 1'b0, 1'b0, 1'b1, 8'hA5);
    rx2    = 8'h00;
    nvalid = 0;
    for (int i = 0; i < 16; i++) begin
      if (o_sv[0]) nvalid++;
      if (i >= 8) rx2 = {rx2[6:0], o_s[0]};
      step(2'd2, 1'b0, 1'b0, (i == 7), 8'h3C);
    end
    check("t4_valids", 0, 8'(nvalid),    8'd16);
    check("t4_word2",  0, rx2,           8'h3C);
    check("t4_busy",   0, 8'(o_busy[0]), 8'h00);

    // rotate from 81, then abort a partial SIPO frame
    step(2'd1, 1'b0, 1'b0, 1'b0, 8'h00);
    send_byte(8'h81);
    check("t6_par", 0, o_par[0], 8'h81);
    step(2'd3, 1'b0, 1'b0, 1'b0, 8'h00);
    check("t6_rot1", 0, o_par[0], 8'h03);
    check("t6_rot1", 1, o_par[1], 8'hC0);
    step(2'd3, 1'b0, 1'b0, 1'b0, 8'h00);
    check("t6_rot2", 0, o_par[0], 8'h06);
    check("t6_rot2", 1, o_par[1], 8'h60);
    step(2'd3, 1'b0, 1'b0, 1'b0, 8'h00);
    check("t6_rot3", 0, o_par[0], 8'h0C);
    check("t6_rot3", 1, o_par[1], 8'h30);
    step(2'd1, 1'b1, 1'b1, 1'b0, 8'h00);
    step(2'd1, 1'b1, 1'b1, 1'b0, 8'h00);
    step(2'd1, 1'b1, 1'b1, 1'b0, 8'h00);
    step(2'd3, 1'b0, 1'b0, 1'b0, 8'h00);
    step(2'd1, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int k = 7; k >= 1; k--) begin
      step(2'd1, 1'b1, (k == 7 || k == 6 || k <= 1), 1'b0, 8'h00);
      check("t6_no_early", 0, 8'(o_pv[0]), 8'h00);
    end
    step(2'd1, 1'b1, 1'b1, 1'b0, 8'h00);
    check("t6_par", 0, o_par[0],    8'hC3);
    check("t6_pv",  0, 8'(o_pv[0]), 8'h01);
    check("t6_par", 1, o_par[1],    8'hC3);
    step(2'd0, 1'b0, 1'b0, 1'b0, 8'h00);

    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
